// File: rtl/cmos_capture.sv
// Camera pixel-bus capture: aligns to whole frames, skips start-up frames,
// writes active pixels into the DDR write FIFO and checks frame geometry.
module cmos_capture #(
  parameter int H_ActivePix = 1280,
  parameter int V_ActivePix = 768,
  parameter int SKIP_FRAMES = 10
) (
  input  logic       cmos_clk,
  input  logic       rstn,
  input  logic       capture_on,
  input  logic       cmos_vsync,
  input  logic       cmos_href,
  input  logic [7:0] cmos_data,
  input  logic       FIFO_FULL,
  output logic       wfifo_req,
  output logic [7:0] wfifo_data,
  output logic       frame_start,
  output logic       frame_done,
  output logic       frame_err,
  output logic       overflow,
  output logic       capturing,
  output logic [7:0] frame_cnt
);

  localparam logic [10:0] HExp    = 11'(H_ActivePix);
  localparam logic [9:0]  VExp    = 10'(V_ActivePix);
  localparam logic [7:0]  SkipLim = 8'(SKIP_FRAMES);

  typedef enum logic [1:0] {
    SKIP,
    WAIT_VS,
    CAPTURE,
    DROP
  } state_t;

  logic [1:0]  rst_sync_q;
  logic        rst_n;

  logic        vs_d0_q, vs_d1_q;
  logic        href_d0_q, href_d1_q;
  logic [7:0]  data_d0_q;

  state_t      state_q, state_d;
  logic [7:0]  skip_cnt_q, skip_cnt_d;
  logic [10:0] x_cnt_q, x_cnt_d;
  logic [9:0]  y_cnt_q, y_cnt_d;
  logic        line_err_q, line_err_d;
  logic        overflow_q, overflow_d;
  logic        frame_start_q, frame_start_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_err_q, frame_err_d;
  logic [7:0]  frame_cnt_q, frame_cnt_d;
  logic        wfifo_req_q, wfifo_req_d;
  logic [7:0]  wfifo_data_q;

  logic        vs_fall, vs_rise, href_fall;
  logic [10:0] x_inc;
  logic [9:0]  y_inc;
  logic [9:0]  y_end;
  logic        line_end_bad;
  logic        frame_good;
  logic        start_now;

  // Reset asserts asynchronously but is released only on a clock edge.
  always_ff @(posedge cmos_clk or negedge rstn) begin
    if (!rstn) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  always_ff @(posedge cmos_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d0_q   <= 1'b0;
      vs_d1_q   <= 1'b0;
      href_d0_q <= 1'b0;
      href_d1_q <= 1'b0;
      data_d0_q <= 8'd0;
    end else begin
      vs_d0_q   <= cmos_vsync;
      vs_d1_q   <= vs_d0_q;
      href_d0_q <= cmos_href;
      href_d1_q <= href_d0_q;
      data_d0_q <= cmos_data;
    end
  end

  assign vs_fall   = vs_d1_q & ~vs_d0_q;
  assign vs_rise   = ~vs_d1_q & vs_d0_q;
  assign href_fall = href_d1_q & ~href_d0_q;

  assign x_inc = (x_cnt_q == 11'h7FF) ? x_cnt_q : x_cnt_q + 11'd1;
  assign y_inc = (y_cnt_q == 10'h3FF) ? y_cnt_q : y_cnt_q + 10'd1;

  // A line ending on the vs_rise cycle itself still contributes to the verdict.
  assign line_end_bad = href_fall && (x_cnt_q != HExp);
  assign y_end        = href_fall ? y_inc : y_cnt_q;
  assign frame_good   = (y_end == VExp) && !line_err_q && !line_end_bad &&
                        !href_d0_q && !overflow_q;

  always_comb begin
    state_d       = state_q;
    skip_cnt_d    = skip_cnt_q;
    x_cnt_d       = x_cnt_q;
    y_cnt_d       = y_cnt_q;
    line_err_d    = line_err_q;
    overflow_d    = overflow_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_err_d   = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    start_now     = 1'b0;

    case (state_q)
      SKIP: begin
        if (vs_fall) begin
          if (skip_cnt_q < SkipLim) begin
            skip_cnt_d = skip_cnt_q + 8'd1;
          end else if (capture_on) begin
            start_now = 1'b1;
          end else begin
            state_d = WAIT_VS;
          end
        end
      end
      WAIT_VS: begin
        if (vs_fall && capture_on) begin
          start_now = 1'b1;
        end
      end
      CAPTURE: begin
        if (vs_rise) begin
          state_d = WAIT_VS;
          if (frame_good) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt_q + 8'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else if (href_d0_q && FIFO_FULL) begin
          overflow_d = 1'b1;
          state_d    = DROP;
        end else begin
          if (href_d0_q) begin
            x_cnt_d = x_inc;
          end
          if (href_fall) begin
            if (x_cnt_q != HExp) begin
              line_err_d = 1'b1;
            end
            y_cnt_d = y_inc;
            x_cnt_d = 11'd0;
          end
        end
      end
      DROP: begin
        if (vs_rise) begin
          state_d     = WAIT_VS;
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = SKIP;
      end
    endcase

    if (start_now) begin
      state_d       = CAPTURE;
      frame_start_d = 1'b1;
      x_cnt_d       = 11'd0;
      y_cnt_d       = 10'd0;
      line_err_d    = 1'b0;
      overflow_d    = 1'b0;
    end
  end

  assign wfifo_req_d = (state_q == CAPTURE) & href_d0_q & ~FIFO_FULL & ~vs_rise;

  always_ff @(posedge cmos_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SKIP;
      skip_cnt_q    <= 8'd0;
      x_cnt_q       <= 11'd0;
      y_cnt_q       <= 10'd0;
      line_err_q    <= 1'b0;
      overflow_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
      wfifo_req_q   <= 1'b0;
      wfifo_data_q  <= 8'd0;
    end else begin
      state_q       <= state_d;
      skip_cnt_q    <= skip_cnt_d;
      x_cnt_q       <= x_cnt_d;
      y_cnt_q       <= y_cnt_d;
      line_err_q    <= line_err_d;
      overflow_q    <= overflow_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
      wfifo_req_q   <= wfifo_req_d;
      wfifo_data_q  <= data_d0_q;
    end
  end

  assign wfifo_req   = wfifo_req_q;
  assign wfifo_data  = wfifo_data_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;
  assign capturing   = (state_q == CAPTURE);
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/cmos_capture.md
Name: cmos_capture

Overview:
- Receive-side counterpart of the VGA display path. Samples the camera pixel bus (vsync/href/8-bit data) on the pixel clock and pushes active pixels into the write FIFO that feeds DDR.
- Aligns capture to whole frames, discards start-up frames, and checks each frame's geometry against the VGA active size.
- Reports per-frame status pulses and sticky error flags to the Ethernet/DDR control logic.

Parameters:
- H_ActivePix, 1280, expected pixels per line (href-high cycles).
- V_ActivePix, 768, expected lines per frame.
- SKIP_FRAMES, 10, number of frame starts discarded after reset (sensor settling). Range 0..255.

Ports:
- cmos_clk  input  1  pixel clock; all logic on posedge.
- rstn  input  1  asynchronous active-low reset. Asserts immediately; releases synchronously to cmos_clk.
- capture_on  input  1  level; enables capture of new frames.
- cmos_vsync  input  1  frame sync, active high.
- cmos_href  input  1  line valid, active high.
- cmos_data  input  8  pixel data, valid when href high.
- FIFO_FULL  input  1  write FIFO full.
- wfifo_req  output  1  FIFO write enable.
- wfifo_data  output  8  FIFO write data.
- frame_start  output  1  one-cycle pulse when a captured frame begins.
- frame_done  output  1  one-cycle pulse when a captured frame ends with correct geometry and no overflow.
- frame_err  output  1  one-cycle pulse when a captured frame ends bad (geometry mismatch or overflow).
- overflow  output  1  sticky; set on a dropped pixel, cleared at next frame_start.
- capturing  output  1  high in CAPTURE state.
- frame_cnt  output  8  count of good frames; wraps 255 to 0.

Behaviour:
- Input stage:
  - cmos_vsync, cmos_href and cmos_data are registered into stage d0; vsync and href also into d1.
  - vs_fall = vs_d1 & ~vs_d0; vs_rise = ~vs_d1 & vs_d0; href_fall = href_d1 & ~href_d0.
- Reset values: all outputs 0; state SKIP; skip_cnt, x_cnt, y_cnt and line_err all 0.
- Reset mid-frame: the partial frame is never captured; capture resumes only after a fresh vs_fall with the skip rule satisfied.
- States: SKIP, WAIT_VS, CAPTURE, DROP.
- SKIP:
  - On vs_fall with skip_cnt < SKIP_FRAMES: skip_cnt increments.
  - On vs_fall with skip_cnt == SKIP_FRAMES: go to WAIT_VS' start rule on that same edge. If capture_on, enter CAPTURE; otherwise go to WAIT_VS.
  - With SKIP_FRAMES=0, the first vs_fall after reset starts capture.
- WAIT_VS: on vs_fall with capture_on, enter CAPTURE; otherwise stay.
- Entering CAPTURE:
  - frame_start pulses in the cycle after the vs_fall cycle.
  - x_cnt, y_cnt, line_err and overflow clear.
- CAPTURE:
  - Each cycle with href_d0 high: x_cnt increments (11 bit, saturates at 2047).
  - On href_fall: line_err is set if x_cnt != H_ActivePix; y_cnt increments (10 bit, saturating); x_cnt clears.
  - href_d0 & FIFO_FULL: this pixel is dropped, overflow sets, and the state goes to DROP.
  - On vs_rise: go to WAIT_VS.
    - If y_cnt == V_ActivePix and line_err == 0 and overflow == 0: pulse frame_done and increment frame_cnt.
    - Otherwise pulse frame_err.
  - If href_d0 is still high at vs_rise, the truncated line counts as an error; no pixel is written in the vs_rise cycle.
  - Simultaneous vs_rise and FIFO_FULL: vs_rise wins; go to WAIT_VS and pulse frame_err.
- DROP:
  - No writes.
  - On vs_rise: go to WAIT_VS and pulse frame_err.
  - The next frame may start on the following vs_fall.
- Write path:
  - wfifo_req <= (state==CAPTURE) & href_d0 & ~FIFO_FULL & ~vs_rise.
  - wfifo_data <= data_d0 every cycle.
  - Latency is 2 cmos_clk cycles from pins to wfifo_req/wfifo_data; wfifo_req is never asserted while FIFO_FULL is high in the same sample cycle.
- capture_on:
  - Deassert mid-frame: the current frame completes normally, then the block stays in WAIT_VS.
  - Assert mid-frame: no effect until the next vs_fall.
- Status pulses: frame_done and frame_err are mutually exclusive, exactly one per captured frame.

Test Plan:
- Settle skip: H=8, V=4, SKIP_FRAMES=2, capture_on=1, 4 clean frames -> frames 1-2 produce no wfifo_req; frames 3 and 4 each give frame_start, 32 writes and frame_done; frame_cnt=2.
- Data integrity and latency: pixel data = incrementing counter -> wfifo_data equals the input sequence, wfifo_req rises exactly 2 cycles after the first href-high pin cycle, and there are no gaps within a line.
- Geometry error: one line with 7 pixels, or a frame with 3 lines -> frame_err pulse, no frame_done, frame_cnt unchanged; the next clean frame gives frame_done.
- Overflow: FIFO_FULL high for 1 cycle mid-line 2 -> writes stop at that pixel, overflow=1, the rest of the frame is dropped, frame_err at vsync; overflow clears at the next frame_start.
- Reset mid-frame: rstn low during line 2 of a captured frame -> all outputs 0 immediately; with SKIP_FRAMES=0 the next full frame is captured from its first pixel.
- capture_on toggling: deassert mid-frame -> that frame finishes with frame_done and later frames are ignored; reassert mid-frame -> capture begins at the next vs_fall only.
